// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-and-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - combinational two's-complement conditional negate
module cond_negate #(
  parameter int W = 4
) (
  input  logic [W-1:0] data_in,
  input  logic         neg,
  output logic [W-1:0] data_out
);

  // Negation is ~x+1 truncated to W bits, so a zero input stays zero.
  assign data_out = neg ? (~data_in + W'(1)) : data_in;

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - iterative shift-and-add multiplier with valid/ready handshakes
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [PW-1:0]    partial, acc_next, product_next;
  logic             accept, last_iter;

  assign accept    = in_valid && (state == IDLE);
  assign last_iter = (cnt == LAST_CNT);

  // Operand magnitudes are formed before capture so the loop only works on unsigned values.
  cond_negate #(.W(WIDTH)) u_neg_a (
    .data_in  (a),
    .neg      (is_signed && a[WIDTH-1]),
    .data_out (mag_a_in)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .data_in  (b),
    .neg      (is_signed && b[WIDTH-1]),
    .data_out (mag_b_in)
  );

  // One partial product per cycle: multiplicand masked by the current multiplier bit, shifted into place.
  always_comb begin
    partial  = '0;
    partial  = {{WIDTH{1'b0}}, (mag_a & {WIDTH{mag_b[cnt]}})} << cnt;
    acc_next = acc + partial;
  end

  // Sign is reapplied once, to the completed magnitude.
  cond_negate #(.W(PW)) u_neg_p (
    .data_in  (acc_next),
    .neg      (neg),
    .data_out (product_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = CALC;
      end
      CALC: begin
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture, accumulation and result load; product is held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        mag_a <= mag_a_in;
        mag_b <= mag_b_in;
        neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc   <= '0;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last_iter) product <= product_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - self-checking bench for seq_shift_add_mult
module tb_seq_shift_add_mult;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       product;
  logic             busy;

  int applied;
  int miscompares;

  seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic       vs;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic on the operands' numeric values.
  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input logic s);
    int vx, vy, p;
    logic [31:0] pw;
    vx = s ? int'($signed(x)) : int'(x);
    vy = s ? int'($signed(y)) : int'(y);
    p  = vx * vy;
    pw = p;
    return pw[7:0];
  endfunction

  // Runs one operation; scrambles inputs during the calculation and holds off out_ready for bp cycles.
  task automatic do_op(input logic [3:0] op_a, input logic [3:0] op_b, input logic op_s,
                       input int bp, input logic [7:0] exp, input string name);
    int lat;
    logic [7:0] held;
    @(negedge clk);
    chk({name, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    a         = op_a;
    b         = op_b;
    is_signed = op_s;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid  = $urandom_range(0, 1);
      a         = 4'($urandom);
      b         = 4'($urandom);
      is_signed = 1'($urandom);
      if (in_ready !== 1'b0 || busy !== 1'b1) chk({name, "_calc_ready_busy"}, {in_ready, busy}, 2'b01);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, WIDTH);
    chk({name, "_product"}, product, exp);
    held = product;
    for (int i = 0; i < bp; i++) begin
      in_valid = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0)
        chk({name, "_hold"}, {out_valid, in_ready, product}, {2'b10, held});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_handshake"}, {out_valid, in_ready, busy}, 3'b010);
    chk({name, "_product_kept"}, product, exp);
  endtask

  vec_t vecs[12];

  initial begin
    applied     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    is_signed   = 1'b0;
    out_ready   = 1'b1;

    vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[2]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[3]  = '{4'h0, 4'hB, 1'b1, 8'h00};
    vecs[4]  = '{4'h0, 4'hF, 1'b0, 8'h00};
    vecs[5]  = '{4'h6, 4'h7, 1'b0, 8'h2A};
    vecs[6]  = '{4'h3, 4'h5, 1'b0, 8'h0F};
    vecs[7]  = '{4'h2, 4'h3, 1'b1, 8'h06};
    vecs[8]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[9]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    vecs[10] = '{4'h7, 4'hF, 1'b1, 8'hF9};
    vecs[11] = '{4'hB, 4'h0, 1'b1, 8'h00};

    #12;
    chk("reset_state", {in_ready, out_valid, busy, product}, {3'b100, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vs, 0, vecs[i].exp, $sformatf("vec%0d", i));

    do_op(4'h6, 4'h7, 1'b0, 5, 8'h2A, "backpressure");

    // Abort mid-calculation after two iterations.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 4'h5;
    b         = 4'h5;
    is_signed = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_calc", {out_valid, in_ready, busy, product}, {3'b010, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'h2, 4'h3, 1'b1, 0, 8'h06, "after_reset");

    for (int i = 0; i < 150; i++) begin
      logic [3:0] ra, rb;
      logic       rs;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, $urandom_range(0, 2), ref_mul(ra, rb, rs), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
